// File: rtl/dclk_rx_pkg.sv
// Shared types and sizing for the serial link receiver.
package dclk_rx_pkg;

  // Flit field widths; the flit is header + payload + address.
  localparam int unsigned HDR_SZ  = 2;
  localparam int unsigned PL_SZ   = 4;
  localparam int unsigned ADDR_SZ = 2;
  localparam int unsigned FLIT_W  = HDR_SZ + PL_SZ + ADDR_SZ;

  // Receiver states, shared with router-level assertions.
  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    RX_RECV = 2'd1,
    RX_HOLD = 2'd2
  } rx_state_e;

  // Bit counter width: one spare bit so the count never wraps inside a frame.
  function automatic int unsigned rx_cnt_width(input int unsigned w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/dclk_rx_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input.
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic s1;

  // Capture the async input and let the first stage settle for one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/dclk_rx.sv
// Serial link receiver: synchronises the line, deserialises one flit LSB
// first after a start bit, and offers it to the router with rx_req/rx_ack.
// channel_busy throttles the far transmitter from start detection until
// the flit has been accepted.
module dclk_rx
  import dclk_rx_pkg::*;
#(
  parameter int routerid = -1,
  parameter     port     = "unknown"
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              serial_in,
  output logic              channel_busy,
  output logic [FLIT_W-1:0] parallel_out,
  output logic              rx_req,
  input  logic              rx_ack,
  output logic              rx_active,
  output logic              rx_err
);

  localparam int unsigned W     = FLIT_W;
  localparam int unsigned CNT_W = rx_cnt_width(W);

  rx_state_e        state_q;
  rx_state_e        state_d;
  logic             s2;
  logic             s2_q;
  logic [W-1:0]     shreg;
  logic [W-1:0]     shreg_nxt;
  logic [CNT_W-1:0] cnt;
  logic             start;
  logic             last_bit;
  logic             take;
  logic             err_set;

  // Debug identifiers and the LSB that falls out of the shifter have no
  // hardware consumer.
  logic unused_dbg;
  assign unused_dbg = (routerid > -1) ^ (|port) ^ shreg[0];

  sync2 u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (serial_in),
    .q     (s2)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RX_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode and per-cycle actions.
  // A start bit is accepted only as a fresh 0->1 edge on the synchronised
  // line, so a 1 left over from an illegal early start (seen during HOLD)
  // is flagged once and then ignored until the line drops back to 0.
  always_comb begin
    state_d   = state_q;
    start     = 1'b0;
    last_bit  = 1'b0;
    take      = 1'b0;
    err_set   = 1'b0;
    shreg_nxt = {s2, shreg[W-1:1]};
    case (state_q)
      RX_IDLE: begin
        if (s2) begin
          if (!s2_q) begin
            start   = 1'b1;
            state_d = RX_RECV;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      RX_RECV: begin
        if (cnt == CNT_W'(W - 1)) begin
          last_bit = 1'b1;
          state_d  = RX_HOLD;
        end
      end
      RX_HOLD: begin
        if (s2 && !s2_q) begin
          err_set = 1'b1;
        end
        if (rx_ack) begin
          take    = 1'b1;
          state_d = RX_IDLE;
        end
      end
      default: begin
        state_d = RX_IDLE;
      end
    endcase
  end

  // Shifter, bit counter, edge history and registered handshake outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_q         <= 1'b0;
      shreg        <= '0;
      cnt          <= '0;
      parallel_out <= '0;
      rx_req       <= 1'b0;
      channel_busy <= 1'b0;
      rx_active    <= 1'b0;
      rx_err       <= 1'b0;
    end else begin
      s2_q <= s2;
      if (err_set) begin
        rx_err <= 1'b1;
      end
      if (start) begin
        cnt          <= '0;
        channel_busy <= 1'b1;
        rx_active    <= 1'b1;
      end
      if (state_q == RX_RECV) begin
        shreg <= shreg_nxt;
        cnt   <= cnt + CNT_W'(1);
      end
      if (last_bit) begin
        parallel_out <= shreg_nxt;
        rx_req       <= 1'b1;
        rx_active    <= 1'b0;
      end
      if (take) begin
        rx_req       <= 1'b0;
        channel_busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dclk_rx.sv
// Directed and random bench for dclk_rx; the bench plays the far
// transmitter and the router, with a scoreboard of sent flits.
module tb_dclk_rx;
  import dclk_rx_pkg::*;

  localparam int unsigned W = FLIT_W;

  logic         clk = 1'b0;
  logic         reset;
  logic         serial_in;
  logic         channel_busy;
  logic [W-1:0] parallel_out;
  logic         rx_req;
  logic         rx_ack;
  logic         rx_active;
  logic         rx_err;

  int           checks   = 0;
  int           failures = 0;
  logic [W-1:0] sb[$];
  int           cyc      = 0;
  logic         cb_d1    = 1'b0;
  logic         cb_d2    = 1'b0;
  int           ack_mode = 0;
  bit           err_watch = 1'b0;
  int           n_xfer   = 0;
  int           t_start  = 0;
  int           t_req    = 0;

  dclk_rx #(.routerid(0), .port("east")) dut (
    .clk          (clk),
    .reset        (reset),
    .serial_in    (serial_in),
    .channel_busy (channel_busy),
    .parallel_out (parallel_out),
    .rx_req       (rx_req),
    .rx_ack       (rx_ack),
    .rx_active    (rx_active),
    .rx_err       (rx_err)
  );

  always #5 clk = ~clk;

  // Cycle counter and the far transmitter's two-cycle view of channel_busy.
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    cb_d1 <= channel_busy;
    cb_d2 <= cb_d1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tx_wait_ready();
    int n;
    n = 0;
    while (cb_d2 !== 1'b0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk("tx_ready_timeout", {31'd0, cb_d2}, 32'd0);
  endtask

  task automatic send_bits(input logic [W-1:0] d, input int unsigned nbits);
    tx_wait_ready();
    serial_in = 1'b1;
    t_start   = cyc;
    @(negedge clk);
    for (int unsigned i = 0; i < nbits; i++) begin
      serial_in = d[i];
      @(negedge clk);
    end
  endtask

  task automatic send_flit(input logic [W-1:0] d);
    sb.push_back(d);
    send_bits(d, W);
    serial_in = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, sb.size(), 32'd0);
  endtask

  task automatic wait_req(input string tag);
    int n;
    n = 0;
    while (!rx_req && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, rx_req}, 32'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, {31'd0, channel_busy}, 32'd0);
    chk({tag, "_req"}, {31'd0, rx_req}, 32'd0);
    chk({tag, "_active"}, {31'd0, rx_active}, 32'd0);
    chk({tag, "_err"}, {31'd0, rx_err}, 32'd0);
    chk({tag, "_data"}, parallel_out, 32'd0);
  endtask

  // Router side: drives rx_ack by mode and scores every transfer.
  initial begin : ack_proc
    int           ack_wait;
    bit           prev_xfer;
    bit           prev_req;
    logic [W-1:0] e;
    ack_wait  = -1;
    prev_xfer = 1'b0;
    prev_req  = 1'b0;
    rx_ack    = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_xfer) chk("req_drop_after_xfer", {31'd0, rx_req}, 32'd0);
      if (rx_req && !prev_req) t_req = cyc;
      prev_req = rx_req;
      case (ack_mode)
        0: rx_ack = 1'b1;
        1: rx_ack = 1'b0;
        default: begin
          if (!rx_req) begin
            rx_ack   = 1'b0;
            ack_wait = -1;
          end else begin
            if (ack_wait < 0) ack_wait = int'($urandom_range(0, 10));
            if (ack_wait == 0) begin
              rx_ack = 1'b1;
            end else begin
              rx_ack = 1'b0;
              ack_wait--;
            end
          end
        end
      endcase
      prev_xfer = rx_req && rx_ack && !reset;
      if (prev_xfer) begin
        n_xfer++;
        ack_wait = -1;
        chk("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("flit_data", parallel_out, e);
        end
        if (err_watch) chk("rx_err_clear", {31'd0, rx_err}, 32'd0);
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    int n0;
    reset     = 1'b1;
    serial_in = 1'b0;
    tick(3);
    chk_all_zero("reset");
    reset = 1'b0;
    tick(3);

    // 1: single flit, ack tied high, latency from start bit to rx_req
    ack_mode = 0;
    send_flit(8'hA5);
    wait_drain("t1_drain");
    chk("t1_latency", t_req - t_start, W + 3);
    chk("t1_err", {31'd0, rx_err}, 32'd0);

    // 2: all-zero and all-one flits back to back
    send_flit('0);
    send_flit('1);
    wait_drain("t2_drain");
    chk("t2_err", {31'd0, rx_err}, 32'd0);

    // 3: router stalls, transmitter must stay off the line
    ack_mode = 1;
    send_flit(8'h3C);
    fork
      send_flit(8'hC3);
      begin
        tick(50);
        chk("t3_busy", {31'd0, channel_busy}, 32'd1);
        chk("t3_line_idle", {31'd0, serial_in}, 32'd0);
        chk("t3_req_held", {31'd0, rx_req}, 32'd1);
        chk("t3_data_held", parallel_out, 32'h3C);
        chk("t3_tx_stalled", sb.size(), 32'd2);
        ack_mode = 0;
      end
    join
    wait_drain("t3_drain");

    // 5: early start bit while holding a flit
    ack_mode = 1;
    send_flit(8'h96);
    wait_req("t5_req");
    serial_in = 1'b1;
    tick(5);
    chk("t5_err_set", {31'd0, rx_err}, 32'd1);
    chk("t5_req_held", {31'd0, rx_req}, 32'd1);
    chk("t5_data_held", parallel_out, 32'h96);
    ack_mode = 0;
    tick(6);
    chk("t5_no_second_req", {31'd0, rx_req}, 32'd0);
    chk("t5_busy_low", {31'd0, channel_busy}, 32'd0);
    chk("t5_sb_empty", sb.size(), 32'd0);
    serial_in = 1'b0;
    tick(3);
    chk("t5_err_sticky", {31'd0, rx_err}, 32'd1);

    // 4: reset in the middle of a frame
    send_bits(8'h5A, 5);
    chk("t4_active_before", {31'd0, rx_active}, 32'd1);
    #2 reset = 1'b1;
    #1 chk_all_zero("t4_reset");
    serial_in = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(3);
    send_flit(8'h81);
    wait_drain("t4_drain");
    chk("t4_err", {31'd0, rx_err}, 32'd0);

    // 6: random flits with random router acceptance delay
    err_watch = 1'b1;
    ack_mode  = 2;
    n0        = n_xfer;
    for (int i = 0; i < 1000; i++) begin
      send_flit(W'($urandom));
    end
    wait_drain("t6_drain");
    chk("t6_count", n_xfer - n0, 32'd1000);
    chk("t6_err", {31'd0, rx_err}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
